// File: rtl/i2c_byte_master.sv
// i2c_byte_master: single-byte I2C master bit engine.
//   Sequence: START, 7-bit address + R/W, address ACK, one data byte
//   (write or read), data ACK/NACK, STOP. Runs entirely on clk_100; a
//   quarter-period prescaler (QDIV cycles per quarter) paces the SCL slots.
//   The pads are open-drain, so *_oe=1 pulls the line low and 0 releases it.
// Ports:
//   clk_100, rst     clock, async active-high reset
//   start            request; accepted only when idle and not in the done cycle
//   addr, rw, wdata  transaction parameters, captured on accept
//   busy, done       in-flight flag, one-cycle completion pulse
//   ack_err, rdata   slave NACK flag, read byte (held until next accept)
//   scl_oe, sda_oe   pull-low enables
//   scl_i, sda_i     pad levels (scl_i used only with clock stretching)
// Optional feature: define I2C_CLK_STRETCH_EN to let a slave hold SCL low;
//   the quarter ending q1 is extended until scl_i reads high.
module i2c_byte_master #(
  parameter int QDIV = 125
) (
  input  logic       clk_100,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_i,
  input  logic       sda_i
);

  localparam int PW = (QDIV > 1) ? $clog2(QDIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_AACK, S_DATA, S_DACK, S_STOP
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [PW-1:0]   r_pre;
  logic [1:0]      r_q;
  logic [2:0]      r_bit;
  logic [7:0]      r_sh;
  logic [7:0]      r_wdata;
  logic            r_rw;
  logic            r_busy, r_done, r_ack_err;
  logic [7:0]      r_rdata;

  logic w_tick, w_hold, w_adv, w_samp, w_last, w_accept, w_slot_low;
  logic w_scl_oe, w_sda_oe;

`ifdef I2C_CLK_STRETCH_EN
  // SCL was released in q1; if the wire is still low a slave is stretching.
  assign w_hold = (r_q == 2'd1) && !scl_i;
`else
  assign w_hold = 1'b0;
  logic w_unused_scl;
  assign w_unused_scl = scl_i;
`endif

  assign w_tick     = (r_pre == PW'(QDIV - 1));
  assign w_adv      = (r_state != S_IDLE) && w_tick && !w_hold;
  assign w_samp     = w_adv && (r_q == 2'd2);
  assign w_last     = w_adv && (r_q == 2'd3);
  // The done cycle still reads IDLE; blocking it gives the one-cycle gap.
  assign w_accept   = (r_state == S_IDLE) && start && !r_done;
  assign w_slot_low = (r_q == 2'd0) || (r_q == 2'd3);

  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_scl_oe    = 1'b0;
    w_sda_oe    = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_START;
      S_START: begin
        // q0,q1 both released; q2 SDA falls under high SCL; q3 SCL low.
        w_scl_oe = (r_q == 2'd3);
        w_sda_oe = r_q[1];
        if (w_last) w_state_nxt = S_ADDR;
      end
      S_ADDR: begin
        w_scl_oe = w_slot_low;
        w_sda_oe = !r_sh[7];
        if (w_last && (r_bit == 3'd7)) w_state_nxt = S_AACK;
      end
      S_AACK: begin
        w_scl_oe = w_slot_low;
        if (w_last) w_state_nxt = r_ack_err ? S_STOP : S_DATA;
      end
      S_DATA: begin
        w_scl_oe = w_slot_low;
        w_sda_oe = !r_rw && !r_sh[7];
        if (w_last && (r_bit == 3'd7)) w_state_nxt = S_DACK;
      end
      S_DACK: begin
        // Write: slave ACKs. Read: master NACKs by leaving SDA released.
        w_scl_oe = w_slot_low;
        if (w_last) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        // q0 SDA low under low SCL; q1,q2 SCL released; q3 SDA rises.
        w_scl_oe = (r_q == 2'd0);
        w_sda_oe = (r_q != 2'd3);
        if (w_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      r_pre     <= '0;
      r_q       <= 2'd0;
      r_bit     <= 3'd0;
      r_sh      <= 8'd0;
      r_wdata   <= 8'd0;
      r_rw      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ack_err <= 1'b0;
      r_rdata   <= 8'd0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_busy    <= 1'b1;
        r_ack_err <= 1'b0;
        r_rdata   <= 8'd0;
        r_rw      <= rw;
        r_wdata   <= wdata;
        r_sh      <= {addr, rw};
        r_bit     <= 3'd0;
        r_q       <= 2'd0;
        r_pre     <= '0;
      end else if (r_state != S_IDLE) begin
        // A held tick parks the prescaler at QDIV-1 and retries each cycle.
        if (!w_tick)    r_pre <= r_pre + 1'b1;
        else if (w_adv) r_pre <= '0;
        if (w_adv) r_q <= r_q + 2'd1;
        if (w_samp) begin
          case (r_state)
            S_AACK: if (sda_i) r_ack_err <= 1'b1;
            S_DATA: if (r_rw) r_rdata <= {r_rdata[6:0], sda_i};
            S_DACK: if (!r_rw && sda_i) r_ack_err <= 1'b1;
            default: ;
          endcase
        end
        if (w_last) begin
          case (r_state)
            S_ADDR, S_DATA: begin
              r_bit <= r_bit + 3'd1;
              r_sh  <= {r_sh[6:0], 1'b0};
            end
            S_AACK: begin
              r_sh  <= r_wdata;
              r_bit <= 3'd0;
            end
            S_STOP: begin
              r_done <= 1'b1;
              r_busy <= 1'b0;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign ack_err = r_ack_err;
  assign rdata   = r_rdata;
  assign scl_oe  = w_scl_oe;
  assign sda_oe  = w_sda_oe;

endmodule
